zion_rr_clr_reg_arbiter: RTL and testbench
==========================================

Name: zion_rr_clr_reg_arbiter

Overview:
- Round-robin arbiter that shares one clearable output holding register among NUM_REQ requesters.
- Each requester presents a valid/data word. The block grants one requester per transfer, latches its data into the shared register and presents it downstream with valid/ready.
- A synchronous clear (iClr) flushes the register back to INI_DATA.
- Sits in front of shared datapath registers where several producers feed one clearable pipeline stage.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DW, 32, data width per requester.
- INI_DATA, 0, value of oDat after reset or clear (DW bits).
- IDW, $clog2(NUM_REQ), grant-index width (derived; not overridable).

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high; clock clk.
- iClr  in  1  synchronous clear of the holding register and arbitration pointer.
- iReqVld  in  NUM_REQ  per-requester request valid.
- iReqDat  in  NUM_REQ*DW  packed request data; requester i occupies bits [i*DW +: DW].
- oReqRdy  out  NUM_REQ  per-requester ready; at most one bit set.
- oVld  out  1  holding register contains valid data.
- oDat  out  DW  holding register data.
- oGntId  out  IDW  index of the requester whose data is in oDat.
- iRdy  in  1  downstream ready.

Behaviour:
- Reset values (rst=1 at posedge): oVld=0, oDat=INI_DATA, oGntId=0, round-robin pointer ptr=0.
- oReqRdy is combinational and 0 while rst=1.
- State: EMPTY (oVld=0) / FULL (oVld=1).
- Slot free condition: slotFree = !oVld | iRdy. This gives a same-cycle pass-through refill, so 1 transfer/cycle throughput.
- Arbitration:
  - When slotFree and !iClr, scan requesters from ptr upward with wrap-around. The first i with iReqVld[i]=1 wins, and oReqRdy = one-hot(i).
  - Otherwise oReqRdy=0.
- Accept (some oReqRdy[i] & iReqVld[i]):
  - Next cycle: oDat=iReqDat[i], oGntId=i, oVld=1, ptr=(i+1) mod NUM_REQ.
  - Latency from request accept to oVld is 1 cycle.
- Downstream pop (oVld & iRdy) with no accept: next oVld=0. oDat and oGntId hold their last value.
- oVld=1 with iRdy=0: oDat, oGntId and oVld hold. oReqRdy=0.
- iClr=1 (synchronous, lower priority than rst):
  - Next cycle: oVld=0, oDat=INI_DATA, oGntId=0, ptr=0.
  - oReqRdy=0 in the iClr cycle, so no request is accepted.
  - A buffered entry is dropped even if iRdy=1 in that cycle; downstream must ignore oVld in the iClr cycle.
- Pointer only advances on accept. Idle cycles and pops do not move it.
- No requests while slotFree: state unchanged apart from a pop.
- A requester may drop iReqVld before being granted; no state is kept per requester.
- Wrap-around: ptr=NUM_REQ-1 and winner NUM_REQ-1 gives ptr=0.

Optional Feature:
- Macro: ZION_RR_ARB_PRIO_EN.
- When defined:
  - Extra input iReqPrio, NUM_REQ bits, is added.
  - If any requester with iReqVld&iReqPrio exists, arbitration is restricted to that set: round-robin from ptr among prioritized requesters.
  - Otherwise normal round-robin applies.
  - ptr update rule is unchanged: (winner+1) mod NUM_REQ.
- When undefined: port absent, pure round-robin.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, iReqVld=0 -> oVld=0, oDat=INI_DATA, oReqRdy=0000 after reset.
2. All requesting with iRdy=1 constantly, iReqDat[i]=32'h10+i, NUM_REQ=4 -> oGntId sequence 0,1,2,3,0 on consecutive cycles, oDat 0x10,0x11,0x12,0x13,0x10, oVld held 1.
3. Backpressure: only req2 valid (data 0xAB), iRdy=0 for 3 cycles -> oVld=1, oDat=0xAB held, oReqRdy=0000 while full. iRdy=1 then pops, and req2 is re-accepted the same cycle.
4. Clear mid-stream: oVld=1, oDat=0x55, iClr=1 with iRdy=1 and req1 valid -> oReqRdy=0000 in that cycle. Next cycle oVld=0, oDat=INI_DATA, ptr=0; req0 then wins before req1 if both are valid.
5. Wrap and sparse requests: after a grant to 3 (ptr=0), only req1 and req3 valid -> grant order 1,3,1,3.
6. ZION_RR_ARB_PRIO_EN: all four valid, iReqPrio=0100 -> req2 granted every accept. Drop iReqPrio -> round-robin resumes at 3,0,1.

Source files
------------

// File: rtl/zion_rr_clr_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : zion_rr_clr_reg_arbiter
//  Purpose  : Round-robin arbiter feeding one clearable valid/ready holding
//             register shared by NUM_REQ requesters.
//  Option   : define ZION_RR_ARB_PRIO_EN to add the iReqPrio priority-set input
//  Revision : 1.0  initial release
// ============================================================================
module zion_rr_clr_reg_arbiter #(
  parameter int              NUM_REQ  = 4,
  parameter int              DW       = 32,
  parameter logic [DW-1:0]   INI_DATA = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         iClr,
  input  logic [NUM_REQ-1:0]           iReqVld,
  input  logic [NUM_REQ*DW-1:0]        iReqDat,
`ifdef ZION_RR_ARB_PRIO_EN
  input  logic [NUM_REQ-1:0]           iReqPrio,
`endif
  output logic [NUM_REQ-1:0]           oReqRdy,
  output logic                         oVld,
  output logic [DW-1:0]                oDat,
  output logic [$clog2(NUM_REQ)-1:0]   oGntId,
  input  logic                         iRdy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int IW1 = IDW + 1;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DW-1:0]        r_dat;
  logic [IDW-1:0]       r_gnt_id;
  logic [IDW-1:0]       r_ptr;

  logic [NUM_REQ-1:0]   w_cand;
  logic                 w_slot_free;
  logic                 w_found;
  logic                 w_gnt;
  logic [IDW-1:0]       w_win;
  logic [IW1-1:0]       w_idx_ext;
  logic [DW-1:0]        w_win_dat;
  logic [IDW-1:0]       w_ptr_nxt;

`ifdef ZION_RR_ARB_PRIO_EN
  logic [NUM_REQ-1:0]   w_prio_set;
  assign w_prio_set = iReqVld & iReqPrio;
  // Prioritised requesters shadow everyone else whenever at least one is pending.
  assign w_cand     = (|w_prio_set) ? w_prio_set : iReqVld;
`else
  assign w_cand     = iReqVld;
`endif

  assign oVld        = (r_state == ST_FULL);
  assign oDat        = r_dat;
  assign oGntId      = r_gnt_id;
  assign w_slot_free = !oVld || iRdy;
  assign w_gnt       = w_slot_free && !iClr && w_found;

  // Scan from the pointer upward with wrap; first candidate wins.
  always_comb begin
    w_found   = 1'b0;
    w_win     = '0;
    w_idx_ext = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx_ext = {1'b0, r_ptr} + IW1'(k);
      if (w_idx_ext >= IW1'(NUM_REQ)) begin
        w_idx_ext = w_idx_ext - IW1'(NUM_REQ);
      end
      if (!w_found && w_cand[w_idx_ext[IDW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx_ext[IDW-1:0];
      end
    end
  end

  always_comb begin
    w_win_dat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == IDW'(i)) begin
        w_win_dat = iReqDat[i*DW +: DW];
      end
    end
  end

  always_comb begin
    oReqRdy = '0;
    if (!rst && w_gnt) begin
      oReqRdy[w_win] = 1'b1;
    end
  end

  assign w_ptr_nxt = (w_win == IDW'(NUM_REQ - 1)) ? '0 : (w_win + 1'b1);

  // A clear drops the buffered entry even when downstream pops in that cycle.
  always_comb begin
    w_state_nxt = r_state;
    if (iClr) begin
      w_state_nxt = ST_EMPTY;
    end else if (w_gnt) begin
      w_state_nxt = ST_FULL;
    end else if ((r_state == ST_FULL) && iRdy) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || iClr) begin
      r_dat    <= INI_DATA;
      r_gnt_id <= '0;
      r_ptr    <= '0;
    end else if (w_gnt) begin
      r_dat    <= w_win_dat;
      r_gnt_id <= w_win;
      r_ptr    <= w_ptr_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_zion_rr_clr_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_zion_rr_clr_reg_arbiter
//  Purpose  : Directed self-checking bench with a scoreboard of granted words.
//  Revision : 1.0  initial release
// ============================================================================
module tb_zion_rr_clr_reg_arbiter;

  localparam int          NR  = 4;
  localparam int          DW  = 32;
  localparam logic [31:0] INI = 32'hDEAD_0000;

  logic            clk = 1'b0;
  logic            rst;
  logic            iClr;
  logic            iRdy;
  logic [NR-1:0]   iReqVld;
  logic [NR*DW-1:0] iReqDat;
`ifdef ZION_RR_ARB_PRIO_EN
  logic [NR-1:0]   iReqPrio;
`endif
  logic [NR-1:0]   oReqRdy;
  logic            oVld;
  logic [DW-1:0]   oDat;
  logic [1:0]      oGntId;

  logic            m_vld;
  logic [31:0]     m_dat;
  logic [1:0]      m_gid;
  logic [1:0]      m_ptr;
  logic [33:0]     sb[$];
  int              n_cmp = 0;
  int              n_mis = 0;

  always #5 clk = ~clk;

  zion_rr_clr_reg_arbiter #(
    .NUM_REQ  (NR),
    .DW       (DW),
    .INI_DATA (INI)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .iClr     (iClr),
    .iReqVld  (iReqVld),
    .iReqDat  (iReqDat),
`ifdef ZION_RR_ARB_PRIO_EN
    .iReqPrio (iReqPrio),
`endif
    .oReqRdy  (oReqRdy),
    .oVld     (oVld),
    .oDat     (oDat),
    .oGntId   (oGntId),
    .iRdy     (iRdy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] cand, input logic [1:0] ptr);
    for (int k = 0; k < NR; k++) begin
      int j;
      j = (int'(ptr) + k) % NR;
      if (cand[j]) return j;
    end
    return -1;
  endfunction

  // Called at posedge+1 with inputs already driven; ends at the next posedge+1.
  task automatic tick(input string tag);
    logic [3:0]  cand;
    logic [3:0]  exp_rdy;
    logic [33:0] e;
    int          w;
    w       = -1;
    exp_rdy = '0;
    #4;
    cand = iReqVld;
`ifdef ZION_RR_ARB_PRIO_EN
    if ((iReqVld & iReqPrio) != '0) cand = iReqVld & iReqPrio;
`endif
    if (!rst && !iClr && (!m_vld || iRdy)) w = pick(cand, m_ptr);
    if (w >= 0) exp_rdy[w] = 1'b1;
    chk({tag, ".rdy"}, 32'(oReqRdy), 32'(exp_rdy));
    if (rst || iClr) begin
      m_vld = 1'b0; m_dat = INI; m_gid = '0; m_ptr = '0;
    end else if (w >= 0) begin
      sb.push_back({2'(w), iReqDat[w*DW +: DW]});
      m_vld = 1'b1;
      m_ptr = 2'((w + 1) % NR);
    end else if (m_vld && iRdy) begin
      m_vld = 1'b0;
    end
    @(posedge clk);
    #1;
    if (w >= 0) begin
      e     = sb.pop_front();
      m_gid = e[33:32];
      m_dat = e[31:0];
    end
    chk({tag, ".vld"}, 32'(oVld), 32'(m_vld));
    chk({tag, ".dat"}, oDat, m_dat);
    chk({tag, ".gid"}, 32'(oGntId), 32'(m_gid));
  endtask

  initial begin
    rst = 1'b1; iClr = 1'b0; iRdy = 1'b0; iReqVld = '0;
`ifdef ZION_RR_ARB_PRIO_EN
    iReqPrio = '0;
`endif
    for (int i = 0; i < NR; i++) iReqDat[i*DW +: DW] = 32'h10 + 32'(i);
    m_vld = 1'b0; m_dat = INI; m_gid = '0; m_ptr = '0;
    @(posedge clk);
    #1;

    // Reset, then idle
    tick("rst0");
    iReqVld = 4'hF;
    tick("rst1");
    rst = 1'b0; iReqVld = '0;
    tick("idle");
    chk("t1.dat", oDat, INI);
    chk("t1.vld", 32'(oVld), 32'd0);

    // All requesting with continuous pop
    iReqVld = 4'hF; iRdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick("t2");
      chk("t2.gidc", 32'(oGntId), 32'(i % NR));
      chk("t2.datc", oDat, 32'h10 + 32'(i % NR));
    end

    // Backpressure with a single requester
    iReqVld = 4'b0100; iReqDat[2*DW +: DW] = 32'hAB;
    tick("t3acc");
    chk("t3.datc", oDat, 32'hAB);
    iRdy = 1'b0;
    repeat (3) tick("t3hold");
    chk("t3.hold", oDat, 32'hAB);
    iRdy = 1'b1;
    tick("t3pop");
    chk("t3.regid", 32'(oGntId), 32'd2);

    // Clear mid-stream
    iReqDat[1*DW +: DW] = 32'h55; iReqVld = 4'b0010;
    tick("t4ld");
    chk("t4.datc", oDat, 32'h55);
    iClr = 1'b1;
    tick("t4clr");
    chk("t4.clrdat", oDat, INI);
    chk("t4.clrvld", 32'(oVld), 32'd0);
    iClr = 1'b0; iReqVld = 4'b0011;
    tick("t4post");
    chk("t4.gidc", 32'(oGntId), 32'd0);

    // Wrap-around and sparse requests
    iReqVld = 4'b1000;
    tick("t5w");
    chk("t5.gid3", 32'(oGntId), 32'd3);
    iReqVld = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick("t5");
      chk("t5.gidc", 32'(oGntId), (i % 2 == 0) ? 32'd1 : 32'd3);
    end

`ifdef ZION_RR_ARB_PRIO_EN
    // Priority set restricts arbitration
    iReqVld = 4'hF; iReqPrio = 4'b0100;
    repeat (3) begin
      tick("t6p");
      chk("t6.pgid", 32'(oGntId), 32'd2);
    end
    iReqPrio = '0;
    for (int i = 0; i < 3; i++) begin
      tick("t6r");
      chk("t6.rgid", 32'(oGntId), 32'((3 + i) % NR));
    end
`endif

    iReqVld = '0;
    tick("drain");
    chk("end.vld", 32'(oVld), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
